// File: rtl/reg_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reg_scoreboard: pending-write counters for late-result producers that |
// | raise a decode stall when forwarding cannot cover a source operand.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [4:0] issue_dst,
  input  logic       wb_valid,
  input  logic [4:0] wb_dst,
  input  logic       flush,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  output logic       stall_d,
  output logic       busy_any,
  output logic       err_overflow,
  output logic       err_underflow
);

  localparam int               SLOTS   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SLOTS-1:0] pend_eff;
  logic [SLOTS-1:0] nonzero;
  logic [SLOTS-1:0] ovf_hit;
  logic [SLOTS-1:0] unf_hit;

  // Slot 0 is the hardwired zero register and never holds a count.
  assign pend_eff[0] = 1'b0;
  assign nonzero[0]  = 1'b0;
  assign ovf_hit[0]  = 1'b0;
  assign unf_hit[0]  = 1'b0;

  genvar r;
  generate
    for (r = 1; r < SLOTS; r++) begin : g_slot
      if (r < NREG) begin : g_live
        logic [CNT_W-1:0] cnt;
        logic             inc;
        logic             dec;

        assign inc = issue_valid && (issue_dst == 5'(r));
        assign dec = wb_valid && (wb_dst == 5'(r));

        always_ff @(posedge clk) begin
          if (reset || flush) begin
            cnt <= '0;
          end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
          end
        end

        // A same-cycle writeback retires one pending write before the consumer reaches E.
        assign pend_eff[r] = (cnt != '0) && !(dec && (cnt == CNT_ONE));
        assign nonzero[r]  = (cnt != '0);
        assign ovf_hit[r]  = inc && !dec && (cnt == CNT_MAX);
        assign unf_hit[r]  = dec && !inc && (cnt == '0);
      end else begin : g_absent
        assign pend_eff[r] = 1'b0;
        assign nonzero[r]  = 1'b0;
        assign ovf_hit[r]  = 1'b0;
        assign unf_hit[r]  = 1'b0;
      end
    end
  endgenerate

  // Error flags are sticky across flush; a flushed cycle cannot raise them.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (!flush) begin
      if (|ovf_hit) err_overflow  <= 1'b1;
      if (|unf_hit) err_underflow <= 1'b1;
    end
  end

  assign stall_d  = !reset && !flush && (pend_eff[rs_d] || pend_eff[rt_d]);
  assign busy_any = !reset && (|nonzero);

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// Directed and randomized checks of reg_scoreboard against a count-per-register model.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset, issue_valid, wb_valid, flush;
  logic [4:0] issue_dst, wb_dst, rs_d, rt_d;
  logic       stall_d, busy_any, err_overflow, err_underflow;

  int total = 0;
  int bad   = 0;

  localparam int MAXC = 3;
  int m_cnt[32];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .flush(flush), .rs_d(rs_d), .rt_d(rt_d),
    .stall_d(stall_d), .busy_any(busy_any),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  function automatic int eff(input logic [4:0] rr);
    int v;
    if (rr == 5'd0) return 0;
    v = m_cnt[rr];
    if (wb_valid && wb_dst == rr && v > 0) v = v - 1;
    return v;
  endfunction

  function automatic bit exp_stall();
    if (reset || flush) return 1'b0;
    return (eff(rs_d) > 0) || (eff(rt_d) > 0);
  endfunction

  function automatic bit exp_busy();
    bit b = 1'b0;
    if (reset) return 1'b0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag);
    bit es, eb;
    es = exp_stall();
    eb = exp_busy();
    total++;
    assert (stall_d === es) else begin
      bad++; $error("FAIL %s stall_d observed=%0b expected=%0b", tag, stall_d, es);
    end
    total++;
    assert (busy_any === eb) else begin
      bad++; $error("FAIL %s busy_any observed=%0b expected=%0b", tag, busy_any, eb);
    end
    total++;
    assert (err_overflow === m_ovf) else begin
      bad++; $error("FAIL %s err_overflow observed=%0b expected=%0b", tag, err_overflow, m_ovf);
    end
    total++;
    assert (err_underflow === m_unf) else begin
      bad++; $error("FAIL %s err_underflow observed=%0b expected=%0b", tag, err_underflow, m_unf);
    end
  endtask

  task automatic model_edge();
    bit inc, dec;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      inc = issue_valid && issue_dst != 5'd0;
      dec = wb_valid && wb_dst != 5'd0;
      if (!(inc && dec && issue_dst == wb_dst)) begin
        if (inc) begin
          if (m_cnt[issue_dst] < MAXC) m_cnt[issue_dst]++;
          else m_ovf = 1'b1;
        end
        if (dec) begin
          if (m_cnt[wb_dst] > 0) m_cnt[wb_dst]--;
          else m_unf = 1'b1;
        end
      end
    end
  endtask

  // Inputs are already driven; check at the falling edge, then commit at the rising edge.
  task automatic finish_cycle(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag, input bit iv, input int idst, input bit wv,
                      input int wdst, input bit fl, input int rs, input int rt, input bit rst);
    reset       = rst;
    issue_valid = iv;
    issue_dst   = 5'(idst);
    wb_valid    = wv;
    wb_dst      = 5'(wdst);
    flush       = fl;
    rs_d        = 5'(rs);
    rt_d        = 5'(rt);
    finish_cycle(tag);
  endtask

  initial begin
    int pick;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // Reset with active-looking inputs, then idle.
    step("rst0", 1, 5, 1, 5, 1, 5, 5, 1);
    step("rst1", 0, 0, 0, 0, 0, 5, 5, 1);
    step("idle", 0, 0, 0, 0, 0, 5, 5, 0);

    // Single load to r5 and its consumer.
    step("ld_c0", 1, 5, 0, 0, 0, 0, 0, 0);
    step("ld_c1", 0, 0, 0, 0, 0, 5, 0, 0);
    step("ld_c2", 0, 0, 0, 0, 0, 5, 0, 0);
    step("ld_c3", 0, 0, 1, 5, 0, 5, 0, 0);
    step("ld_c4", 0, 0, 0, 0, 0, 5, 0, 0);

    // Saturate r7, then drain it.
    step("sat_i1", 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat_i2", 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat_i3", 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat_i4", 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat_w1", 0, 0, 1, 7, 0, 0, 7, 0);
    step("sat_w2", 0, 0, 1, 7, 0, 0, 7, 0);
    step("sat_w3", 0, 0, 1, 7, 0, 0, 7, 0);
    step("sat_end", 0, 0, 0, 0, 0, 0, 7, 0);

    // Simultaneous issue and writeback on r9, then r0 writes.
    step("same_i", 1, 9, 0, 0, 0, 0, 0, 0);
    step("same_iw", 1, 9, 1, 9, 0, 0, 0, 0);
    step("same_chk", 0, 0, 0, 0, 0, 9, 0, 0);
    step("same_wb", 0, 0, 1, 9, 0, 9, 0, 0);
    step("r0_iss", 1, 0, 0, 0, 0, 0, 0, 0);
    step("r0_chk", 0, 0, 1, 0, 0, 0, 0, 0);

    // Flush overriding an issue.
    step("fl_i3", 1, 3, 0, 0, 0, 0, 0, 0);
    step("fl_i4", 1, 4, 0, 0, 0, 0, 0, 0);
    step("fl_go", 1, 3, 0, 0, 1, 3, 4, 0);
    step("fl_after", 0, 0, 0, 0, 0, 3, 4, 0);

    // Underflow stickiness, then a mid-operation reset.
    step("unf_wb", 0, 0, 1, 12, 0, 12, 0, 0);
    step("unf_fl", 0, 0, 0, 0, 1, 0, 0, 0);
    step("unf_hold", 1, 2, 0, 0, 0, 0, 0, 0);
    step("unf_i6", 1, 6, 0, 0, 0, 2, 0, 0);
    step("mid_rst", 1, 6, 1, 2, 0, 2, 6, 1);
    step("post_rst", 0, 0, 0, 0, 0, 2, 6, 0);

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      rs_d  = 5'($urandom_range(0, 7));
      rt_d  = 5'($urandom_range(0, 7));
      pick  = $urandom_range(1, 7);
      if (m_cnt[pick] > 0 && $urandom_range(0, 2) != 0) begin
        wb_valid = 1'b1;
        wb_dst   = 5'(pick);
      end else begin
        wb_valid = ($urandom_range(0, 39) == 0);
        wb_dst   = 5'($urandom_range(0, 7));
      end
      issue_dst   = 5'($urandom_range(0, 7));
      issue_valid = 1'b0;
      if (!exp_stall()) issue_valid = $urandom_range(0, 1) == 1;
      finish_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
